// File: rtl/axil_arbiter_2to1.sv
// axil_arbiter_2to1: two AXI4-Lite masters sharing one AXI4-Lite slave.
// Write and read channels are arbitrated independently, one transaction per
// channel at a time, with round-robin between the two masters.
// Grants and FSM states are registered. Channel signals are muxed only from
// the registered grant, so no request valid reaches a grant combinationally.
// Optional build macro AXIL_ARB_TIMEOUT_EN adds a per-channel watchdog. On
// expiry it completes the stuck transaction locally with SLVERR.
module axil_arbiter_2to1 #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // master 0
  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic                      s0_axi_awvalid,
  output logic                      s0_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic                      s0_axi_wvalid,
  output logic                      s0_axi_wready,
  output logic [1:0]                s0_axi_bresp,
  output logic                      s0_axi_bvalid,
  input  logic                      s0_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]                s0_axi_rresp,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,
  // master 1
  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic                      s1_axi_awvalid,
  output logic                      s1_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic                      s1_axi_wvalid,
  output logic                      s1_axi_wready,
  output logic [1:0]                s1_axi_bresp,
  output logic                      s1_axi_bvalid,
  input  logic                      s1_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]                s1_axi_rresp,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,
  // shared slave
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  // current owners
  output logic [1:0]                wr_grant,
  output logic [1:0]                rd_grant
);

  localparam int DW = AXI_DATA_WIDTH;
  localparam int AW = AXI_ADDR_WIDTH;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE, W_ADDR, W_RESP
`ifdef AXIL_ARB_TIMEOUT_EN
    , W_ERR
`endif
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE, R_ADDR, R_DATA
`ifdef AXIL_ARB_TIMEOUT_EN
    , R_ERR
`endif
  } rd_state_e;

  // Master ports gathered into packed arrays so the grant can index them.
  logic [1:0][AW-1:0] s_awaddr, s_araddr;
  logic [1:0][DW-1:0] s_wdata, s_rdata;
  logic [1:0][1:0]    s_bresp, s_rresp;
  logic [1:0]         s_awvalid, s_awready, s_wvalid, s_wready;
  logic [1:0]         s_bvalid, s_bready, s_arvalid, s_arready;
  logic [1:0]         s_rvalid, s_rready;

  assign s_awaddr  = {s1_axi_awaddr,  s0_axi_awaddr};
  assign s_awvalid = {s1_axi_awvalid, s0_axi_awvalid};
  assign s_wdata   = {s1_axi_wdata,   s0_axi_wdata};
  assign s_wvalid  = {s1_axi_wvalid,  s0_axi_wvalid};
  assign s_bready  = {s1_axi_bready,  s0_axi_bready};
  assign s_araddr  = {s1_axi_araddr,  s0_axi_araddr};
  assign s_arvalid = {s1_axi_arvalid, s0_axi_arvalid};
  assign s_rready  = {s1_axi_rready,  s0_axi_rready};

  assign {s1_axi_awready, s0_axi_awready} = s_awready;
  assign {s1_axi_wready,  s0_axi_wready}  = s_wready;
  assign {s1_axi_bvalid,  s0_axi_bvalid}  = s_bvalid;
  assign {s1_axi_bresp,   s0_axi_bresp}   = s_bresp;
  assign {s1_axi_arready, s0_axi_arready} = s_arready;
  assign {s1_axi_rvalid,  s0_axi_rvalid}  = s_rvalid;
  assign {s1_axi_rdata,   s0_axi_rdata}   = s_rdata;
  assign {s1_axi_rresp,   s0_axi_rresp}   = s_rresp;

  // ---------------- write channel ----------------
  wr_state_e wr_state_q, wr_state_d;
  logic      wr_gnt_q, wr_gnt_d;    // owner index
  logic      wr_last_q, wr_last_d;  // last completed owner
  logic      aw_done_q, aw_done_d;
  logic      w_done_q, w_done_d;
  logic      aw_hs, w_hs;
  logic [1:0] wr_req;

  assign wr_req   = s_awvalid | s_wvalid;
  assign wr_grant = (wr_state_q == W_IDLE) ? 2'b00 : (wr_gnt_q ? 2'b10 : 2'b01);

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic wr_to, rd_to;
  logic ar_done_q, ar_done_d;
  assign wr_to = (wr_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rd_to = (rd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Write FSM next state and channel muxing from the registered grant.
  always_comb begin
    wr_state_d    = wr_state_q;
    wr_gnt_d      = wr_gnt_q;
    wr_last_d     = wr_last_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    m_axi_awaddr  = s_awaddr[wr_gnt_q];
    m_axi_wdata   = s_wdata[wr_gnt_q];
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    s_awready     = '0;
    s_wready      = '0;
    s_bvalid      = '0;
    s_bresp       = '0;
`ifdef AXIL_ARB_TIMEOUT_EN
    wr_cnt_d      = (wr_state_q == W_IDLE) ? '0 : wr_cnt_q + 1'b1;
`endif
    case (wr_state_q)
      W_IDLE: begin
        if (|wr_req) begin
          // Tie goes to whoever did not win last time.
          wr_gnt_d   = (&wr_req) ? ~wr_last_q : wr_req[1];
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_axi_awvalid       = s_awvalid[wr_gnt_q] & ~aw_done_q;
        s_awready[wr_gnt_q] = m_axi_awready & ~aw_done_q;
        m_axi_wvalid        = s_wvalid[wr_gnt_q] & ~w_done_q;
        s_wready[wr_gnt_q]  = m_axi_wready & ~w_done_q;
        aw_hs = m_axi_awvalid & m_axi_awready;
        w_hs  = m_axi_wvalid & m_axi_wready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) wr_state_d = W_RESP;
      end
      W_RESP: begin
        m_axi_bready       = s_bready[wr_gnt_q];
        s_bvalid[wr_gnt_q] = m_axi_bvalid;
        s_bresp[wr_gnt_q]  = m_axi_bresp;
        if (m_axi_bvalid && s_bready[wr_gnt_q]) begin
          wr_last_d  = wr_gnt_q;
          wr_state_d = W_IDLE;
        end
      end
`ifdef AXIL_ARB_TIMEOUT_EN
      W_ERR: begin
        // Soak up whatever the owner still has pending, then answer SLVERR.
        s_awready[wr_gnt_q] = ~aw_done_q;
        s_wready[wr_gnt_q]  = ~w_done_q;
        if (s_awvalid[wr_gnt_q] && !aw_done_q) aw_done_d = 1'b1;
        if (s_wvalid[wr_gnt_q]  && !w_done_q)  w_done_d  = 1'b1;
        if (aw_done_q && w_done_q) begin
          s_bvalid[wr_gnt_q] = 1'b1;
          s_bresp[wr_gnt_q]  = RESP_SLVERR;
          if (s_bready[wr_gnt_q]) begin
            wr_last_d  = wr_gnt_q;
            wr_state_d = W_IDLE;
          end
        end
      end
`endif
      default: wr_state_d = W_IDLE;
    endcase
`ifdef AXIL_ARB_TIMEOUT_EN
    // Expiry wins over any handshake in the same cycle: everything drops.
    if (wr_state_q != W_IDLE && wr_state_q != W_ERR && wr_to) begin
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      s_awready     = '0;
      s_wready      = '0;
      s_bvalid      = '0;
      s_bresp       = '0;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      wr_last_d     = wr_last_q;
      wr_state_d    = W_ERR;
    end
`endif
  end

  // ---------------- read channel ----------------
  rd_state_e rd_state_q, rd_state_d;
  logic      rd_gnt_q, rd_gnt_d;
  logic      rd_last_q, rd_last_d;

  assign rd_grant = (rd_state_q == R_IDLE) ? 2'b00 : (rd_gnt_q ? 2'b10 : 2'b01);

  // Read FSM next state and channel muxing from the registered grant.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_gnt_d      = rd_gnt_q;
    rd_last_d     = rd_last_q;
    m_axi_araddr  = s_araddr[rd_gnt_q];
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    s_arready     = '0;
    s_rvalid      = '0;
    s_rdata       = '0;
    s_rresp       = '0;
`ifdef AXIL_ARB_TIMEOUT_EN
    ar_done_d     = ar_done_q;
    rd_cnt_d      = (rd_state_q == R_IDLE) ? '0 : rd_cnt_q + 1'b1;
`endif
    case (rd_state_q)
      R_IDLE: begin
        if (|s_arvalid) begin
          rd_gnt_d   = (&s_arvalid) ? ~rd_last_q : s_arvalid[1];
          rd_state_d = R_ADDR;
`ifdef AXIL_ARB_TIMEOUT_EN
          ar_done_d  = 1'b0;
`endif
        end
      end
      R_ADDR: begin
        m_axi_arvalid       = s_arvalid[rd_gnt_q];
        s_arready[rd_gnt_q] = m_axi_arready;
        if (m_axi_arvalid && m_axi_arready) begin
          rd_state_d = R_DATA;
`ifdef AXIL_ARB_TIMEOUT_EN
          ar_done_d  = 1'b1;
`endif
        end
      end
      R_DATA: begin
        m_axi_rready       = s_rready[rd_gnt_q];
        s_rvalid[rd_gnt_q] = m_axi_rvalid;
        s_rdata[rd_gnt_q]  = m_axi_rdata;
        s_rresp[rd_gnt_q]  = m_axi_rresp;
        if (m_axi_rvalid && s_rready[rd_gnt_q]) begin
          rd_last_d  = rd_gnt_q;
          rd_state_d = R_IDLE;
        end
      end
`ifdef AXIL_ARB_TIMEOUT_EN
      R_ERR: begin
        s_arready[rd_gnt_q] = ~ar_done_q;
        if (s_arvalid[rd_gnt_q] && !ar_done_q) ar_done_d = 1'b1;
        if (ar_done_q) begin
          s_rvalid[rd_gnt_q] = 1'b1;
          s_rresp[rd_gnt_q]  = RESP_SLVERR;
          if (s_rready[rd_gnt_q]) begin
            rd_last_d  = rd_gnt_q;
            rd_state_d = R_IDLE;
          end
        end
      end
`endif
      default: rd_state_d = R_IDLE;
    endcase
`ifdef AXIL_ARB_TIMEOUT_EN
    if (rd_state_q != R_IDLE && rd_state_q != R_ERR && rd_to) begin
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      s_arready     = '0;
      s_rvalid      = '0;
      s_rdata       = '0;
      s_rresp       = '0;
      ar_done_d     = ar_done_q;
      rd_last_d     = rd_last_q;
      rd_state_d    = R_ERR;
    end
`endif
  end

  // State, grant and last-winner registers; reset favours master 0 first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      wr_gnt_q   <= 1'b0;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rd_state_q <= R_IDLE;
      rd_gnt_q   <= 1'b0;
      rd_last_q  <= 1'b1;
`ifdef AXIL_ARB_TIMEOUT_EN
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      ar_done_q  <= 1'b0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_last_q  <= wr_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rd_state_q <= rd_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_last_q  <= rd_last_d;
`ifdef AXIL_ARB_TIMEOUT_EN
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      ar_done_q  <= ar_done_d;
`endif
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Directed bench for axil_arbiter_2to1: two bus-functional masters, a small
// register-file slave, and per-scenario tasks with hand-computed expectations.
module tb_axil_arbiter_2to1;
  localparam int DW = 32;
  localparam int AW = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // master side
  logic [AW-1:0] awaddr[2], araddr[2];
  logic [DW-1:0] wdata[2], rdata[2];
  logic [1:0]    bresp[2], rresp[2];
  logic awvalid[2], awready[2], wvalid[2], wready[2], bvalid[2], bready[2];
  logic arvalid[2], arready[2], rvalid[2], rready[2];
  // slave side
  logic [AW-1:0] sl_awaddr, sl_araddr;
  logic [DW-1:0] sl_wdata, sl_rdata;
  logic [1:0]    sl_bresp, sl_rresp, wr_grant, rd_grant;
  logic sl_awvalid, sl_awready, sl_wvalid, sl_wready, sl_bvalid, sl_bready;
  logic sl_arvalid, sl_arready, sl_rvalid, sl_rready;

  axil_arbiter_2to1 #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axi_awaddr(awaddr[0]), .s0_axi_awvalid(awvalid[0]), .s0_axi_awready(awready[0]),
    .s0_axi_wdata(wdata[0]), .s0_axi_wvalid(wvalid[0]), .s0_axi_wready(wready[0]),
    .s0_axi_bresp(bresp[0]), .s0_axi_bvalid(bvalid[0]), .s0_axi_bready(bready[0]),
    .s0_axi_araddr(araddr[0]), .s0_axi_arvalid(arvalid[0]), .s0_axi_arready(arready[0]),
    .s0_axi_rdata(rdata[0]), .s0_axi_rresp(rresp[0]), .s0_axi_rvalid(rvalid[0]), .s0_axi_rready(rready[0]),
    .s1_axi_awaddr(awaddr[1]), .s1_axi_awvalid(awvalid[1]), .s1_axi_awready(awready[1]),
    .s1_axi_wdata(wdata[1]), .s1_axi_wvalid(wvalid[1]), .s1_axi_wready(wready[1]),
    .s1_axi_bresp(bresp[1]), .s1_axi_bvalid(bvalid[1]), .s1_axi_bready(bready[1]),
    .s1_axi_araddr(araddr[1]), .s1_axi_arvalid(arvalid[1]), .s1_axi_arready(arready[1]),
    .s1_axi_rdata(rdata[1]), .s1_axi_rresp(rresp[1]), .s1_axi_rvalid(rvalid[1]), .s1_axi_rready(rready[1]),
    .m_axi_awaddr(sl_awaddr), .m_axi_awvalid(sl_awvalid), .m_axi_awready(sl_awready),
    .m_axi_wdata(sl_wdata), .m_axi_wvalid(sl_wvalid), .m_axi_wready(sl_wready),
    .m_axi_bresp(sl_bresp), .m_axi_bvalid(sl_bvalid), .m_axi_bready(sl_bready),
    .m_axi_araddr(sl_araddr), .m_axi_arvalid(sl_arvalid), .m_axi_arready(sl_arready),
    .m_axi_rdata(sl_rdata), .m_axi_rresp(sl_rresp), .m_axi_rvalid(sl_rvalid), .m_axi_rready(sl_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  // Register-file slave: AW and W accepted independently, B one cycle after both.
  logic [DW-1:0] mem [16];
  logic aw_got, w_got, slv_aw_en;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d;
  logic [1:0] slv_aw_gnt;
  int slv_wr_cnt = 0;
  assign sl_awready = slv_aw_en & ~aw_got;
  assign sl_wready  = ~w_got;
  assign sl_arready = ~sl_rvalid;
  assign sl_bresp   = 2'b00;
  assign sl_rresp   = 2'b00;

  // slave behaviour
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_got <= 1'b0; w_got <= 1'b0; sl_bvalid <= 1'b0; sl_rvalid <= 1'b0; sl_rdata <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (sl_awvalid && sl_awready) begin aw_got <= 1'b1; aw_a <= sl_awaddr; slv_aw_gnt <= wr_grant; end
      if (sl_wvalid && sl_wready) begin w_got <= 1'b1; w_d <= sl_wdata; end
      if (aw_got && w_got && !sl_bvalid) begin
        mem[aw_a[5:2]] <= w_d; sl_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
        slv_wr_cnt <= slv_wr_cnt + 1;
      end
      if (sl_bvalid && sl_bready) sl_bvalid <= 1'b0;
      if (sl_arvalid && sl_arready) begin sl_rvalid <= 1'b1; sl_rdata <= mem[sl_araddr[5:2]]; end
      else if (sl_rvalid && sl_rready) sl_rvalid <= 1'b0;
    end
  end

  // monitor: B handshakes, concurrent ownership, read grant order
  int b_cnt[2] = '{0, 0};
  int conc_cnt = 0;
  int rd_switch = 0;
  logic [1:0] rd_prev = 2'b00;
  logic [1:0] gq[$];
  always @(negedge aclk) begin
    for (int m = 0; m < 2; m++) if (bvalid[m] && bready[m]) b_cnt[m] <= b_cnt[m] + 1;
    if (wr_grant == 2'b01 && rd_grant == 2'b10) conc_cnt <= conc_cnt + 1;
    if (rd_grant != 2'b00 && rd_grant != rd_prev) begin
      gq.push_back(rd_grant);
      if (rd_prev != 2'b00) rd_switch <= rd_switch + 1;
    end
    rd_prev <= rd_grant;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    aresetn = 1'b0;
    for (int m = 0; m < 2; m++) begin
      awaddr[m] = '0; awvalid[m] = 0; wdata[m] = '0; wvalid[m] = 0; bready[m] = 0;
      araddr[m] = '0; arvalid[m] = 0; rready[m] = 0;
    end
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic do_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d, input int lead,
                          output logic [1:0] resp, output int t_start, output int t_b, output logic [1:0] g_b);
    bit awd, wd, ok;
    int n;
    @(posedge aclk); #1;
    t_start = cyc; awaddr[m] = a; wdata[m] = d; wvalid[m] = 1; awvalid[m] = (lead == 0);
    awd = 0; wd = 0; ok = 0; n = 0; resp = 2'b11; t_b = -1; g_b = 2'b00;
    while (!(awd && wd) && n < 100) begin
      @(negedge aclk);
      if (awvalid[m] && awready[m]) awd = 1;
      if (wvalid[m] && wready[m]) wd = 1;
      @(posedge aclk); #1; n++;
      if (awd) awvalid[m] = 0;
      if (wd) wvalid[m] = 0;
      if (!awd && n >= lead) awvalid[m] = 1;
    end
    bready[m] = 1;
    while (!ok && n < 200) begin
      @(negedge aclk);
      if (bvalid[m]) begin ok = 1; resp = bresp[m]; t_b = cyc; g_b = wr_grant; end
      @(posedge aclk); #1; n++;
    end
    bready[m] = 0; awvalid[m] = 0; wvalid[m] = 0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL write_wait m%0d: no B response within %0d cycles", m, n);
    end
  endtask

  task automatic do_read(input int m, input logic [AW-1:0] a,
                         output logic [DW-1:0] d, output logic [1:0] resp, output int t_start, output int t_r);
    bit ard, ok;
    int n;
    @(posedge aclk); #1;
    t_start = cyc; araddr[m] = a; arvalid[m] = 1;
    ard = 0; ok = 0; n = 0; d = '1; resp = 2'b11; t_r = -1;
    while (!ard && n < 100) begin
      @(negedge aclk);
      if (arready[m]) ard = 1;
      @(posedge aclk); #1; n++;
    end
    arvalid[m] = 0; rready[m] = 1;
    while (!ok && n < 200) begin
      @(negedge aclk);
      if (rvalid[m]) begin ok = 1; d = rdata[m]; resp = rresp[m]; t_r = cyc; end
      @(posedge aclk); #1; n++;
    end
    rready[m] = 0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL read_wait m%0d: no R response within %0d cycles", m, n);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    awvalid[0] = 1; wvalid[0] = 1; arvalid[1] = 1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++; if (wr_grant !== 2'b00) begin failures++; $display("FAIL reset_wr_grant got=%b exp=00", wr_grant); end
    checks++; if (rd_grant !== 2'b00) begin failures++; $display("FAIL reset_rd_grant got=%b exp=00", rd_grant); end
    checks++; if (sl_awvalid !== 1'b0 || sl_wvalid !== 1'b0 || sl_arvalid !== 1'b0)
      begin failures++; $display("FAIL reset_m_valids got=%b%b%b exp=000", sl_awvalid, sl_wvalid, sl_arvalid); end
    checks++; if (awready[0] !== 1'b0 || wready[0] !== 1'b0 || arready[1] !== 1'b0)
      begin failures++; $display("FAIL reset_s_readys got=%b%b%b exp=000", awready[0], wready[0], arready[1]); end
    checks++; if (rdata[0] !== '0 || bresp[0] !== 2'b00 || rresp[1] !== 2'b00 || bvalid[1] !== 1'b0)
      begin failures++; $display("FAIL reset_resp got=%h/%b/%b/%b exp=0", rdata[0], bresp[0], rresp[1], bvalid[1]); end
    reset_dut();
  endtask

  task automatic test_single_write_read();
    logic [1:0] resp, g; logic [DW-1:0] d; int ts, tb;
    do_write(0, 16'h0004, 32'h0000_1234, 0, resp, ts, tb, g);
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL single_bresp got=%b exp=00", resp); end
    checks++; if (g !== 2'b01 || slv_aw_gnt !== 2'b01) begin failures++; $display("FAIL single_wr_grant got=%b/%b exp=01", slv_aw_gnt, g); end
    checks++; if (tb - ts !== 3) begin failures++; $display("FAIL single_wr_latency got=%0d exp=3", tb - ts); end
    checks++; if (mem[1] !== 32'h0000_1234) begin failures++; $display("FAIL single_slave_data got=%h exp=00001234", mem[1]); end
    do_read(0, 16'h0004, d, resp, ts, tb);
    checks++; if (d !== 32'h0000_1234 || resp !== 2'b00) begin failures++; $display("FAIL single_readback got=%h/%b exp=00001234/00", d, resp); end
    checks++; if (tb - ts !== 2) begin failures++; $display("FAIL single_rd_latency got=%0d exp=2", tb - ts); end
  endtask

  task automatic test_simultaneous_writes();
    logic [1:0] r0, r1, g0, g1, rr; logic [DW-1:0] d; int s0, s1, b0, b1, ts, tr;
    reset_dut();
    fork
      do_write(0, 16'h0008, 32'hAAAA_0000, 0, r0, s0, b0, g0);
      do_write(1, 16'h0008, 32'h5555_0000, 0, r1, s1, b1, g1);
    join
    checks++; if (r0 !== 2'b00 || r1 !== 2'b00) begin failures++; $display("FAIL simul_bresp got=%b/%b exp=00/00", r0, r1); end
    checks++; if (g0 !== 2'b01 || g1 !== 2'b10) begin failures++; $display("FAIL simul_grants got=%b/%b exp=01/10", g0, g1); end
    checks++; if (b0 - s0 !== 3) begin failures++; $display("FAIL simul_m0_first got=%0d exp=3", b0 - s0); end
    checks++; if (b1 - b0 !== 4) begin failures++; $display("FAIL simul_m1_gap got=%0d exp=4", b1 - b0); end
    do_read(0, 16'h0008, d, rr, ts, tr);
    checks++; if (d !== 32'h5555_0000) begin failures++; $display("FAIL simul_final_data got=%h exp=55550000", d); end
  endtask

  task automatic test_wdata_first();
    logic [1:0] resp, g; int ts, tb, wc0, bc0;
    wc0 = slv_wr_cnt; bc0 = b_cnt[1];
    do_write(1, 16'h000C, 32'hCAFE_F00D, 3, resp, ts, tb, g);
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    checks++; if (resp !== 2'b00 || g !== 2'b10) begin failures++; $display("FAIL wfirst_resp got=%b/%b exp=00/10", resp, g); end
    checks++; if (mem[3] !== 32'hCAFE_F00D) begin failures++; $display("FAIL wfirst_data got=%h exp=cafef00d", mem[3]); end
    checks++; if (slv_wr_cnt - wc0 !== 1) begin failures++; $display("FAIL wfirst_slave_writes got=%0d exp=1", slv_wr_cnt - wc0); end
    checks++; if (b_cnt[1] - bc0 !== 1) begin failures++; $display("FAIL wfirst_b_count got=%0d exp=1", b_cnt[1] - bc0); end
  endtask

  task automatic test_concurrent_channels();
    logic [1:0] wr, rr, g; logic [DW-1:0] d; int c0, s0, b0, s1, t1;
    c0 = conc_cnt;
    fork
      do_write(0, 16'h0010, 32'h1111_2222, 0, wr, s0, b0, g);
      do_read(1, 16'h0008, d, rr, s1, t1);
    join
    checks++; if (conc_cnt == c0) begin failures++; $display("FAIL conc_overlap got=0 cycles exp>0"); end
    checks++; if (wr !== 2'b00 || rr !== 2'b00) begin failures++; $display("FAIL conc_resp got=%b/%b exp=00/00", wr, rr); end
    checks++; if (d !== 32'h5555_0000) begin failures++; $display("FAIL conc_rdata got=%h exp=55550000", d); end
  endtask

  task automatic test_fairness();
    logic [DW-1:0] d0, d1; logic [1:0] r0, r1; int a0, a1, t0, t1, sw0;
    reset_dut();
    gq.delete();
    sw0 = rd_switch;
    fork
      begin for (int i = 0; i < 4; i++) do_read(0, 16'h0004, d0, r0, a0, t0); end
      begin for (int j = 0; j < 4; j++) do_read(1, 16'h0008, d1, r1, a1, t1); end
    join
    checks++; if (gq.size() !== 8) begin failures++; $display("FAIL fair_count got=%0d exp=8", gq.size()); end
    for (int k = 0; k < 8 && k < gq.size(); k++) begin
      checks++;
      if (gq[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL fair_order[%0d] got=%b exp=%b", k, gq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    checks++; if (rd_switch != sw0) begin failures++; $display("FAIL fair_idle_gap got=%0d direct switches exp=0", rd_switch - sw0); end
  endtask

`ifdef AXIL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [1:0] resp, g; int ts, tb;
    slv_aw_en = 1'b0;
    do_write(0, 16'h0014, 32'hDEAD_0001, 0, resp, ts, tb, g);
    checks++; if (resp !== 2'b10) begin failures++; $display("FAIL timeout_bresp got=%b exp=10", resp); end
    checks++; if (tb - ts > 19 || tb - ts < 16) begin failures++; $display("FAIL timeout_latency got=%0d exp=16..19", tb - ts); end
    slv_aw_en = 1'b1;
    do_write(1, 16'h0014, 32'hBEEF_0002, 0, resp, ts, tb, g);
    checks++; if (resp !== 2'b00 || g !== 2'b10) begin failures++; $display("FAIL timeout_recover got=%b/%b exp=00/10", resp, g); end
  endtask
`endif

  initial begin
    slv_aw_en = 1'b1;
    for (int m = 0; m < 2; m++) begin
      awaddr[m] = '0; awvalid[m] = 0; wdata[m] = '0; wvalid[m] = 0; bready[m] = 0;
      araddr[m] = '0; arvalid[m] = 0; rready[m] = 0;
    end
    test_reset();
    test_single_write_read();
    test_simultaneous_writes();
    test_wdata_first();
    test_concurrent_channels();
    test_fairness();
`ifdef AXIL_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
